// File: rtl/shift_pkg.sv
`default_nettype none
// ============================================================================
// Package : shift_pkg
// Brief   : Operation codes and helpers shared by the pipelined barrel shifter.
// Rev     : 1.0  initial release
// ============================================================================
package shift_pkg;

  localparam int OP_W = 3;

  typedef logic [OP_W-1:0] op_t;

  localparam op_t SH_LSL = 3'b000;
  localparam op_t SH_LSR = 3'b001;
  localparam op_t SH_ASR = 3'b010;
  localparam op_t SH_ROL = 3'b011;
  localparam op_t SH_ROR = 3'b100;

  // Codes above SH_ROR are reserved and flagged as errors.
  function automatic logic is_legal_op(input op_t op);
    return (op <= SH_ROR);
  endfunction

endpackage : shift_pkg
`default_nettype wire

// File: rtl/shift_pipe_unit_if.sv
`default_nettype none
// ============================================================================
// Interface : shift_pipe_unit_if
// Brief     : Input and result valid/ready streams of the pipelined shifter.
// Rev       : 1.0  initial release
// ============================================================================
interface shift_pipe_unit_if #(
  parameter int WIDTH = 8,
  parameter int TAG_W = 4
);
  import shift_pkg::*;

  localparam int SHAMT_W = $clog2(WIDTH);

  logic               in_valid;
  logic               in_ready;
  op_t                in_op;
  logic [SHAMT_W-1:0] in_shamt;
  logic [WIDTH-1:0]   in_data;
  logic [TAG_W-1:0]   in_tag;

  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   out_data;
  logic               out_carry;
  logic               out_zero;
  logic               out_err;
  logic [TAG_W-1:0]   out_tag;

  // Environment side: produces operations and consumes results.
  modport master (
    output in_valid, in_op, in_shamt, in_data, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_carry, out_zero, out_err, out_tag
  );

  // Shifter side.
  modport slave (
    input  in_valid, in_op, in_shamt, in_data, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_carry, out_zero, out_err, out_tag
  );

endinterface : shift_pipe_unit_if
`default_nettype wire

// File: rtl/shift_stage.sv
`default_nettype none
// ============================================================================
// Module : shift_stage
// Brief  : Combinational conditional shift/rotate by DIST with carry update.
// Rev    : 1.0  initial release
// ============================================================================
module shift_stage
  import shift_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIST  = 1
) (
  input  logic             en,
  input  op_t              op,
  input  logic [WIDTH-1:0] data_in,
  input  logic             carry_in,
  output logic [WIDTH-1:0] data_out,
  output logic             carry_out
);

  // Rotates and illegal ops never touch carry, so it stays at its initial 0.
  always_comb begin
    data_out  = data_in;
    carry_out = carry_in;
    if (en) begin
      case (op)
        SH_LSL: begin
          data_out  = {data_in[WIDTH-DIST-1:0], {DIST{1'b0}}};
          carry_out = data_in[WIDTH-DIST];
        end
        SH_LSR: begin
          data_out  = {{DIST{1'b0}}, data_in[WIDTH-1:DIST]};
          carry_out = data_in[DIST-1];
        end
        SH_ASR: begin
          data_out  = {{DIST{data_in[WIDTH-1]}}, data_in[WIDTH-1:DIST]};
          carry_out = data_in[DIST-1];
        end
        SH_ROL: data_out = {data_in[WIDTH-DIST-1:0], data_in[WIDTH-1:WIDTH-DIST]};
        SH_ROR: data_out = {data_in[DIST-1:0], data_in[WIDTH-1:DIST]};
        default: ;
      endcase
    end
  end

endmodule : shift_stage
`default_nettype wire

// File: rtl/shift_pipe_unit.sv
`default_nettype none
// ============================================================================
// Module : shift_pipe_unit
// Brief  : Pipelined barrel shifter on valid/ready streams, one op per clock.
// Rev    : 1.0  initial release
// ============================================================================
module shift_pipe_unit
  import shift_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  shift_pipe_unit_if.slave bus
);

  localparam int SHAMT_W = $clog2(WIDTH);

  // Bank 0 captures the raw beat; bank k+1 holds the result of shift stage k.
  logic [SHAMT_W:0]                 r_valid;
  logic [SHAMT_W:0][WIDTH-1:0]      r_data;
  logic [SHAMT_W:0]                 r_carry;
  logic [SHAMT_W:0]                 r_err;
  logic [SHAMT_W:0][TAG_W-1:0]      r_tag;
  op_t  [SHAMT_W-1:0]               r_op;
  logic [SHAMT_W-1:0][SHAMT_W-1:0]  r_shamt;
  logic                             r_zero;

  logic [SHAMT_W-1:0][WIDTH-1:0]    w_data;
  logic [SHAMT_W-1:0]               w_carry;
  logic                             w_advance;
  logic                             w_unused_shamt;

  // The whole pipe moves as one; a stalled output freezes every bank.
  assign w_advance    = !r_valid[SHAMT_W] || bus.out_ready;
  assign bus.in_ready = w_advance;

  for (genvar k = 0; k < SHAMT_W; k++) begin : g_stage
    shift_stage #(
      .WIDTH (WIDTH),
      .DIST  (1 << k)
    ) u_stage (
      .en        (r_shamt[k][k]),
      .op        (r_op[k]),
      .data_in   (r_data[k]),
      .carry_in  (r_carry[k]),
      .data_out  (w_data[k]),
      .carry_out (w_carry[k])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      r_data  <= '0;
      r_carry <= '0;
      r_err   <= '0;
      r_tag   <= '0;
      r_op    <= '0;
      r_shamt <= '0;
      r_zero  <= 1'b0;
    end else if (w_advance) begin
      r_valid[0] <= bus.in_valid;
      r_data[0]  <= bus.in_data;
      r_carry[0] <= 1'b0;
      r_err[0]   <= !is_legal_op(bus.in_op);
      r_tag[0]   <= bus.in_tag;
      r_op[0]    <= bus.in_op;
      r_shamt[0] <= bus.in_shamt;
      for (int k = 0; k < SHAMT_W; k++) begin
        r_valid[k+1] <= r_valid[k];
        r_data[k+1]  <= w_data[k];
        r_carry[k+1] <= w_carry[k];
        r_err[k+1]   <= r_err[k];
        r_tag[k+1]   <= r_tag[k];
      end
      for (int k = 0; k < SHAMT_W - 1; k++) begin
        r_op[k+1]    <= r_op[k];
        r_shamt[k+1] <= r_shamt[k];
      end
      r_zero <= (w_data[SHAMT_W-1] == '0);
    end
  end

  // The last shift stage only consumes its own shamt bit.
  assign w_unused_shamt = ^r_shamt[SHAMT_W-1];

  assign bus.out_valid = r_valid[SHAMT_W];
  assign bus.out_data  = r_data[SHAMT_W];
  assign bus.out_carry = r_carry[SHAMT_W];
  assign bus.out_zero  = r_zero;
  assign bus.out_err   = r_err[SHAMT_W];
  assign bus.out_tag   = r_tag[SHAMT_W];

endmodule : shift_pipe_unit
`default_nettype wire
